// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Defines the loader state encoding and the byte/word geometry.
package imem_loader_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream little-endian into 32-bit words.
// Raises word_full in the cycle the final byte of a word is strobed in.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         byte_stb,
    input  logic [BYTE_W-1:0]            byte_in,
    output logic                         word_full,
    output logic [WORD_BYTES*BYTE_W-1:0] word
);

    localparam int unsigned CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0]               byte_cnt;
    logic [WORD_BYTES*BYTE_W-1:0]   asm_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            byte_cnt <= '0;
            asm_q    <= '0;
        end else if (byte_stb) begin
            asm_q[byte_cnt*BYTE_W +: BYTE_W] <= byte_in;
            byte_cnt                         <= byte_cnt + CNT_W'(1);
        end
    end

    // Merge the incoming byte so the full word is available on the same edge.
    always_comb begin
        word = asm_q;
        if (byte_stb) begin
            word[byte_cnt*BYTE_W +: BYTE_W] = byte_in;
        end
    end

    assign word_full = byte_stb && (byte_cnt == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a program image into instruction memory from a byte stream,
// holding the core in reset until the requested number of words is written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_start,
    input  logic [ADDR_W:0]              load_len,
    input  logic                         byte_valid,
    input  logic [BYTE_W-1:0]            byte_data,
    output logic                         byte_ready,
    output logic                         imem_we,
    output logic [ADDR_W-1:0]            imem_addr,
    output logic [WORD_BYTES*BYTE_W-1:0] imem_wdata,
    output logic                         load_done,
    output logic                         cpu_reset
);

    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

    state_t                       state;
    logic [ADDR_W-1:0]            word_idx;
    logic [ADDR_W:0]              len;
    logic [ADDR_W:0]              clamped_len;
    logic                         start_ok;
    logic                         byte_stb;
    logic                         word_full;
    logic [WORD_BYTES*BYTE_W-1:0] word;
    logic                         last_word;

    assign clamped_len = (load_len > DEPTH_LEN) ? DEPTH_LEN : load_len;
    assign start_ok    = load_start && ((state == IDLE) || (state == DONE));
    assign byte_stb    = byte_valid && byte_ready;
    assign last_word   = (({1'b0, word_idx} + (ADDR_W + 1)'(1)) == len);

    imem_word_packer u_packer (
        .clk       (clk),
        .clear     (reset || start_ok),
        .byte_stb  (byte_stb),
        .byte_in   (byte_data),
        .word_full (word_full),
        .word      (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word_idx   <= '0;
            len        <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load_start) begin
                        len      <= clamped_len;
                        word_idx <= '0;
                        state    <= (clamped_len == '0) ? DONE : RECV;
                    end
                end
                RECV: begin
                    if (word_full) begin
                        imem_addr  <= word_idx;
                        imem_wdata <= word;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    // Index is left at the last address on completion so it never leaves range.
                    if (last_word) begin
                        state <= DONE;
                    end else begin
                        word_idx <= word_idx + ADDR_W'(1);
                        state    <= RECV;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign byte_ready = (state == RECV);
    assign imem_we    = (state == WRITE);
    assign load_done  = (state == DONE);
    assign cpu_reset  = (state != DONE);

endmodule

// File: doc/imem_loader.md
# imem_loader

Writes a program image into the instruction memory that `instruction_fetch` reads. It accepts a byte stream over a valid/ready handshake, packs the bytes little-endian into 32-bit words, and issues one memory write per word. While a load is in progress it holds the fetch/CPU side in reset, and releases it when the image is complete. It sits between the host/boot byte source and the instruction-memory write port.

## Interface
Parameters:
- `DEPTH`, 32: number of instruction-memory words.
- `ADDR_W`, 5: word-address width; must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_start`  in  1  single-cycle request to begin a load.
- `load_len`  in  ADDR_W+1  number of words to load; sampled only when `load_start` is accepted.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  program byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  word to write.
- `load_done`  out  1  a complete image is loaded.
- `cpu_reset`  out  1  drives the reset of `instruction_fetch` and the rest of the core.

## Operation
States:
- **IDLE**: entered on reset.
  - `byte_ready`=0, `cpu_reset`=1.
  - On `load_start`, latch `len` = min(`load_len`, DEPTH) and clear `word_idx`, `byte_cnt` and the assembly register.
  - If `len`==0, go to DONE; otherwise go to RECV.
- **RECV**: `byte_ready`=1, `cpu_reset`=1.
  - A byte is accepted when `byte_valid`&`byte_ready`. Byte k (k = `byte_cnt`, 0..3) is placed at bits [8k+7:8k].
  - `byte_cnt` wraps 3→0. Acceptance of the 4th byte moves to WRITE.
- **WRITE**: one cycle only.
  - `imem_we`=1, `imem_addr`=`word_idx`, `imem_wdata`=assembled word, `byte_ready`=0.
  - Next cycle, `word_idx`+1. If `word_idx`+1 == `len` go to DONE, else go to RECV.
- **DONE**: `load_done`=1, `cpu_reset`=0, `byte_ready`=0.
  - `load_start` re-enters the load sequence exactly as from IDLE; `cpu_reset` returns to 1 the next cycle.

Rules:
- `load_start` is ignored in RECV and WRITE.
- Bytes presented outside RECV are not accepted (`byte_ready`=0).
- `load_len` greater than DEPTH is clamped to DEPTH. `word_idx` never exceeds DEPTH-1, so there is no address wrap.
- `imem_addr` and `imem_wdata` hold their last values when `imem_we`=0.
- A reset mid-load discards any partial word and returns to IDLE. Words already written stay in memory.

## Timing
- Reset values: `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `load_done`=0, `cpu_reset`=1. All outputs are registered or decoded from the state register.
- `load_start` sampled in cycle t → RECV in t+1 (`byte_ready` high in t+1), or DONE in t+1 when `len`==0.
- 4th byte accepted in cycle t → `imem_we` high in t+1 → RECV or DONE in t+2.
- Peak rate is one word per 5 cycles.
- Last write in cycle t → `load_done`=1 and `cpu_reset`=0 in t+1.
- `byte_valid` may drop at any time; the loader stalls in RECV indefinitely with no timeout.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum (IDLE, RECV, WRITE, DONE);
  - localparams `WORD_BYTES`=4 and `BYTE_W`=8.
- One sub-module, `imem_word_packer`:
  - holds `byte_cnt` and the 32-bit assembly register;
  - input: byte strobe plus data; outputs: `word_full` pulse and `word`;
  - clear input used on `load_start` and on reset.
- The FSM, `word_idx` and `len` live in `imem_loader`.

## Test plan
- Reset held for 2 cycles → all outputs at their reset values, `cpu_reset`=1; no `imem_we` even if `byte_valid`=1.
- `load_len`=2, bytes 0x13,0x00,0x50,0x00,0xB3,0x01,0x21,0x00 streamed back-to-back:
  - writes addr0=0x00500013 and addr1=0x002101B3, 5 cycles apart;
  - `load_done`=1 and `cpu_reset`=0 one cycle after the second write.
- `load_len`=1 with `byte_valid` toggling every other cycle → exactly one write of the correct word; no byte lost or duplicated.
- `load_len`=0 → DONE one cycle after `load_start`, no writes. `load_len`=40 → exactly 32 writes, addresses 0..31.
- Reset asserted after 2 bytes of word 1 → IDLE. A new load of 1 word then writes addr0 with only the new bytes.
- `load_start` pulsed mid-RECV → ignored. `load_start` in DONE → `cpu_reset` returns to 1 the next cycle and reload begins at addr0.
